// File: rtl/pll_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_phase_ctrl_if
// Description : Phase-step request channel between fabric users and the PLL
//               phase controller. The user side (master) offers a request
//               with req_valid/req_ch/req_dir/req_steps. The controller side
//               (slave) answers with req_ready and the done/err/abort status
//               pulses.
// Signals     : req_valid  user -> ctrl  request valid
//               req_ready  ctrl -> user  request can be accepted
//               req_ch     user -> ctrl  target output channel (PSSEL code)
//               req_dir    user -> ctrl  1 = advance (+1), 0 = retard (-1)
//               req_steps  user -> ctrl  number of steps, 0 allowed
//               done       ctrl -> user  one-cycle pulse, request completed
//               err        ctrl -> user  one-cycle pulse, channel rejected
//               abort      ctrl -> user  one-cycle pulse, killed by lock loss
// Revision    : 1.0  initial release
// ============================================================================
interface pll_phase_ctrl_if #(
    parameter int STEP_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_ch;
    logic              req_dir;
    logic [STEP_W-1:0] req_steps;
    logic              done;
    logic              err;
    logic              abort;

    modport master (
        output req_valid, req_ch, req_dir, req_steps,
        input  req_ready, done, err, abort
    );

    modport slave (
        input  req_valid, req_ch, req_dir, req_steps,
        output req_ready, done, err, abort
    );
endinterface
`default_nettype wire

// File: rtl/pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_phase_ctrl
// Description : Fabric PLL dynamic phase-shift controller. Sequences the PLL
//               out of reset, watches LOCK (with timeout and retry), turns
//               each accepted phase-step request into PSSEL/PSDIR/PSPULSE
//               activity and keeps a per-channel phase position that can be
//               read back combinationally.
// Ports       : clk        system clock, single domain
//               rst        synchronous active-high reset
//               pll_lock   PLL LOCK (asynchronous, synchronised here)
//               pll_reset  PLL RESET
//               pssel      PLL PSSEL
//               psdir      PLL PSDIR (1 = advance)
//               pspulse    PLL PSPULSE
//               req        request channel (slave side)
//               locked     synchronised lock while operational
//               fault      sticky lock-timeout flag
//               rd_ch      position read-back channel select
//               rd_pos     position of rd_ch, 0 for unused codes
// Revision    : 1.0  initial release
// ============================================================================
module pll_phase_ctrl #(
    parameter int NUM_CH       = 7,
    parameter int STEP_W       = 8,
    parameter int POS_W        = 6,
    parameter int RST_CYC      = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_HI     = 4,
    parameter int PULSE_GAP    = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             pll_lock,
    output logic                  pll_reset,
    output logic [2:0]            pssel,
    output logic                  psdir,
    output logic                  pspulse,
    pll_phase_ctrl_if.slave       req,
    output logic                  locked,
    output logic                  fault,
    input  wire logic [2:0]       rd_ch,
    output logic [POS_W-1:0]      rd_pos
);

    // One shared down-the-line counter serves every timed state, so it is
    // sized for the longest interval.
    localparam int c_cnt_max_a = (RST_CYC > LOCK_TIMEOUT) ? RST_CYC : LOCK_TIMEOUT;
    localparam int c_cnt_max_b = (PULSE_HI > PULSE_GAP) ? PULSE_HI : PULSE_GAP;
    localparam int c_cnt_max_c = (c_cnt_max_b > SETUP_CYC) ? c_cnt_max_b : SETUP_CYC;
    localparam int c_cnt_max   = (c_cnt_max_a > c_cnt_max_c) ? c_cnt_max_a : c_cnt_max_c;
    localparam int c_cnt_w     = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_rst_last   = c_cnt_w'(RST_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_to_last    = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hi_last    = c_cnt_w'(PULSE_HI - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(PULSE_GAP - 1);

    localparam logic [2:0] c_st_rst_pll   = 3'd0;
    localparam logic [2:0] c_st_wait_lock = 3'd1;
    localparam logic [2:0] c_st_idle      = 3'd2;
    localparam logic [2:0] c_st_setup     = 3'd3;
    localparam logic [2:0] c_st_phi       = 3'd4;
    localparam logic [2:0] c_st_plo       = 3'd5;

    logic               r_lock_meta;
    logic               r_lock_sync;
    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [STEP_W-1:0]  r_rem;
    logic [2:0]         r_pssel;
    logic               r_psdir;
    logic               r_done_zero;
    logic               r_err;
    logic               r_abort;
    logic               r_fault;
    logic [POS_W-1:0]   r_pos [NUM_CH];

    logic               w_ch_bad;
    logic               w_load;
    logic               w_err_set;
    logic               w_done_zero_set;
    logic               w_done_last;
    logic               w_abort_set;
    logic               w_fault_set;
    logic               w_step;
    logic               w_clr_pos;
    logic [POS_W-1:0]   w_rd_pos;

    // ------------------------------------------------------------------
    // LOCK synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_sync <= r_lock_meta;
        end
    end

    assign w_ch_bad = (int'(req.req_ch) >= NUM_CH);

    // ------------------------------------------------------------------
    // Next-state / strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state    = r_state;
        w_cnt_next      = r_cnt + c_cnt_w'(1);
        w_load          = 1'b0;
        w_err_set       = 1'b0;
        w_done_zero_set = 1'b0;
        w_done_last     = 1'b0;
        w_abort_set     = 1'b0;
        w_fault_set     = 1'b0;
        w_step          = 1'b0;
        w_clr_pos       = 1'b0;

        case (r_state)
            c_st_rst_pll: begin
                if (r_cnt == c_rst_last) begin
                    w_next_state = c_st_wait_lock;
                    w_cnt_next   = '0;
                end
            end

            c_st_wait_lock: begin
                if (r_lock_sync) begin
                    w_next_state = c_st_idle;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_to_last) begin
                    w_next_state = c_st_rst_pll;
                    w_cnt_next   = '0;
                    w_fault_set  = 1'b1;
                    w_clr_pos    = 1'b1;
                end
            end

            c_st_idle: begin
                w_cnt_next = '0;
                if (!r_lock_sync) begin
                    w_next_state = c_st_rst_pll;
                    w_clr_pos    = 1'b1;
                end else if (req.req_valid) begin
                    // Rejected and zero-step requests complete without
                    // leaving IDLE; only real work enters SETUP.
                    if (w_ch_bad) begin
                        w_err_set = 1'b1;
                    end else if (req.req_steps == '0) begin
                        w_done_zero_set = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = c_st_setup;
                    end
                end
            end

            c_st_setup: begin
                if (!r_lock_sync) begin
                    w_next_state = c_st_rst_pll;
                    w_cnt_next   = '0;
                    w_abort_set  = 1'b1;
                    w_clr_pos    = 1'b1;
                end else if (r_cnt == c_setup_last) begin
                    w_next_state = c_st_phi;
                    w_cnt_next   = '0;
                end
            end

            c_st_phi: begin
                if (!r_lock_sync) begin
                    w_next_state = c_st_rst_pll;
                    w_cnt_next   = '0;
                    w_abort_set  = 1'b1;
                    w_clr_pos    = 1'b1;
                end else if (r_cnt == c_hi_last) begin
                    w_next_state = c_st_plo;
                    w_cnt_next   = '0;
                    w_step       = 1'b1;
                end
            end

            c_st_plo: begin
                if (!r_lock_sync) begin
                    w_next_state = c_st_rst_pll;
                    w_cnt_next   = '0;
                    w_abort_set  = 1'b1;
                    w_clr_pos    = 1'b1;
                end else if (r_cnt == c_gap_last) begin
                    w_cnt_next = '0;
                    if (r_rem != '0) begin
                        w_next_state = c_st_phi;
                    end else begin
                        w_next_state = c_st_idle;
                        // done is raised in the final gap cycle itself so
                        // the completion latency is SETUP + N*(HI+GAP).
                        w_done_last  = !rst;
                    end
                end
            end

            default: begin
                w_next_state = c_st_rst_pll;
                w_cnt_next   = '0;
                w_clr_pos    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_rst_pll;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_pssel     <= '0;
            r_psdir     <= 1'b0;
            r_done_zero <= 1'b0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_done_zero <= w_done_zero_set;
            r_err       <= w_err_set;
            r_abort     <= w_abort_set;
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
            if (w_load) begin
                r_pssel <= req.req_ch;
                r_psdir <= req.req_dir;
                r_rem   <= req.req_steps;
            end else if (w_step) begin
                r_rem <= r_rem - STEP_W'(1);
            end
        end
    end

    // Per-channel phase positions, wrapping modulo 2^POS_W.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || w_clr_pos) begin
                r_pos[i] <= '0;
            end else if (w_step && (int'(r_pssel) == i)) begin
                r_pos[i] <= r_psdir ? (r_pos[i] + POS_W'(1)) : (r_pos[i] - POS_W'(1));
            end
        end
    end

    always_comb begin
        w_rd_pos = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(rd_ch) == i) begin
                w_rd_pos = r_pos[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // pspulse is gated by the synchronised lock so a lock drop silences the
    // pulse before the FSM has even left PHI.
    assign pll_reset     = (r_state == c_st_rst_pll);
    assign pspulse       = (r_state == c_st_phi) && r_lock_sync;
    assign pssel         = r_pssel;
    assign psdir         = r_psdir;
    assign locked        = r_lock_sync && ((r_state == c_st_idle) || (r_state == c_st_setup) ||
                                           (r_state == c_st_phi)  || (r_state == c_st_plo));
    assign fault         = r_fault;
    assign rd_pos        = w_rd_pos;
    assign req.req_ready = (r_state == c_st_idle) && r_lock_sync;
    assign req.done      = r_done_zero | w_done_last;
    assign req.err       = r_err;
    assign req.abort     = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_phase_ctrl
// Description : Self-checking bench for pll_phase_ctrl. Directed bring-up,
//               edge, lock-loss and timeout sequences plus randomised
//               phase-step requests checked against a per-channel position
//               model and closed-form latency/pulse-count expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pll_phase_ctrl;
    localparam int NUM_CH = 7;
    localparam int STEP_W = 8;
    localparam int POS_W  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pll_lock = 1'b0;
    logic             pll_reset;
    logic [2:0]       pssel;
    logic             psdir;
    logic             pspulse;
    logic             locked;
    logic             fault;
    logic [2:0]       rd_ch = 3'd0;
    logic [POS_W-1:0] rd_pos;

    pll_phase_ctrl_if #(.STEP_W(STEP_W)) bus ();

    pll_phase_ctrl #(
        .NUM_CH(NUM_CH), .STEP_W(STEP_W), .POS_W(POS_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .pssel    (pssel),
        .psdir    (psdir),
        .pspulse  (pspulse),
        .req      (bus),
        .locked   (locked),
        .fault    (fault),
        .rd_ch    (rd_ch),
        .rd_pos   (rd_pos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_pos [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 8; c++) model_pos[c] = 0;
    endtask

    // Read every channel code, including the unused one, against the model.
    task automatic check_positions(input string tag);
        for (int c = 0; c < 8; c++) begin
            rd_ch = 3'(c);
            #1;
            chk(tag, 32'(rd_pos), 32'(model_pos[c]));
        end
    endtask

    // One complete request: offer it, follow it to its status pulse, then
    // compare latency, pulse shape and positions with the rule-based model.
    task automatic do_req(input int ch, input int dir, input int steps);
        int   k, rises, hi, first_k, exp_lat;
        logic prev, got_done, got_err, got_abort, fin, ready_at_end;
        bit   normal;
        normal = (ch < NUM_CH) && (steps != 0);
        @(negedge clk);
        chk("ready_before_req", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_ch    = 3'(ch);
        bus.req_dir   = dir[0];
        bus.req_steps = STEP_W'(steps);
        k = 0; rises = 0; hi = 0; first_k = 0; prev = 1'b0;
        got_done = 1'b0; got_err = 1'b0; got_abort = 1'b0; fin = 1'b0;
        ready_at_end = 1'b0;
        while (!fin && k < 1000) begin
            @(negedge clk);
            k++;
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.done)  got_done  = 1'b1;
            if (bus.err)   got_err   = 1'b1;
            if (bus.abort) got_abort = 1'b1;
            if (pspulse) begin
                hi++;
                if (!prev) begin
                    rises++;
                    if (first_k == 0) first_k = k;
                end
                chk("pssel_during_pulse", 32'(pssel), 32'(ch));
                chk("psdir_during_pulse", 32'(psdir), 32'(dir));
            end
            prev = pspulse;
            if (normal) chk("ready_low_while_busy", 32'(bus.req_ready), 0);
            ready_at_end = bus.req_ready;
            fin = got_done | got_err | got_abort;
        end
        chk("no_abort", 32'(got_abort), 0);
        if (ch >= NUM_CH) begin
            chk("err_pulse", 32'(got_err), 1);
            chk("err_no_done", 32'(got_done), 0);
            chk("err_latency", 32'(k), 1);
            chk("err_no_pspulse", 32'(rises), 0);
            chk("err_ready_back", 32'(ready_at_end), 1);
        end else if (steps == 0) begin
            chk("zero_done", 32'(got_done), 1);
            chk("zero_no_err", 32'(got_err), 0);
            chk("zero_latency", 32'(k), 1);
            chk("zero_no_pspulse", 32'(rises), 0);
        end else begin
            exp_lat = 2 + 12 * steps;
            chk("req_done", 32'(got_done), 1);
            chk("req_no_err", 32'(got_err), 0);
            chk("req_latency", 32'(k), 32'(exp_lat));
            chk("req_pulse_count", 32'(rises), 32'(steps));
            chk("req_pulse_hi_cycles", 32'(hi), 32'(4 * steps));
            chk("req_first_pulse_k", 32'(first_k), 3);
            model_pos[ch] = (((model_pos[ch] + (dir != 0 ? steps : -steps)) % 64) + 64) % 64;
        end
        check_positions("rd_pos_after_req");
    endtask

    initial begin
        int n, m, k, rises, r;
        logic prev, done_seen, abort_seen;

        bus.req_valid = 1'b0;
        bus.req_ch    = 3'd0;
        bus.req_dir   = 1'b0;
        bus.req_steps = '0;
        model_clear();

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_pll_reset", 32'(pll_reset), 1);
        chk("rst_pspulse", 32'(pspulse), 0);
        chk("rst_pssel", 32'(pssel), 0);
        chk("rst_psdir", 32'(psdir), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_done_err_abort", 32'({bus.done, bus.err, bus.abort}), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_fault", 32'(fault), 0);

        // ---------------- bring-up ----------------
        rst = 1'b0;
        n = 0;
        while (pll_reset && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("bringup_reset_cycles", 32'(n), 16);
        repeat (4) @(negedge clk);
        pll_lock = 1'b1;
        m = 0;
        while (!bus.req_ready && m < 50) begin
            @(negedge clk);
            m++;
        end
        // Two synchroniser stages followed by the WAIT_LOCK exit.
        chk("bringup_ready_delay_2_to_3", 32'((m >= 2 && m <= 3) ? 1 : 0), 1);
        chk("bringup_locked", 32'(locked), 1);
        chk("bringup_fault", 32'(fault), 0);
        chk("bringup_pll_reset_low", 32'(pll_reset), 0);
        check_positions("rd_pos_after_bringup");

        // ---------------- directed requests ----------------
        do_req(2, 1, 3);   // advance
        do_req(5, 0, 1);   // wrap 0 -> 63
        do_req(7, 1, 4);   // rejected channel
        do_req(1, 0, 0);   // zero steps
        do_req(6, 1, 0);   // zero steps, top valid channel

        // ---------------- randomised requests ----------------
        for (int i = 0; i < 20; i++) begin
            do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 6)));
        end

        // ---------------- lock loss during second PHI ----------------
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_ch    = 3'd3;
        bus.req_dir   = 1'b1;
        bus.req_steps = STEP_W'(5);
        k = 0; rises = 0; prev = 1'b0; done_seen = 1'b0; abort_seen = 1'b0;
        while (rises < 2 && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) bus.req_valid = 1'b0;
            if (pspulse && !prev) rises++;
            prev = pspulse;
        end
        chk("ll_second_pulse_k", 32'(k), 15);
        pll_lock = 1'b0;
        n = 0;
        while (pspulse && n < 10) begin
            @(negedge clk);
            n++;
            if (bus.done)  done_seen  = 1'b1;
            if (bus.abort) abort_seen = 1'b1;
        end
        chk("ll_pspulse_low_within_3", 32'((n <= 3) ? 1 : 0), 1);
        m = 0;
        while (!abort_seen && m < 20) begin
            @(negedge clk);
            m++;
            if (bus.done)  done_seen  = 1'b1;
            if (bus.abort) abort_seen = 1'b1;
        end
        chk("ll_abort_pulse", 32'(abort_seen), 1);
        r = 0;
        while (pll_reset && r < 100) begin
            r++;
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        chk("ll_reset_cycles", 32'(r), 16);
        chk("ll_no_done", 32'(done_seen), 0);
        chk("ll_locked_low", 32'(locked), 0);
        model_clear();
        check_positions("rd_pos_after_lockloss");
        pll_lock = 1'b1;
        m = 0;
        while (!bus.req_ready && m < 50) begin
            @(negedge clk);
            m++;
        end
        chk("ll_relock_ready", 32'(bus.req_ready), 1);
        do_req(4, 1, 2);

        // ---------------- lock timeout ----------------
        rst = 1'b1;
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        model_clear();
        rst = 1'b0;
        n = 0;
        while (!fault && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 32'(n), 16 + 4096);
        chk("timeout_pll_reset_again", 32'(pll_reset), 1);
        chk("timeout_locked_low", 32'(locked), 0);
        repeat (10) @(negedge clk);
        pll_lock = 1'b1;
        m = 0;
        while (!locked && m < 100) begin
            @(negedge clk);
            m++;
        end
        chk("timeout_relock_locked", 32'(locked), 1);
        chk("timeout_fault_sticky", 32'(fault), 1);
        check_positions("rd_pos_after_timeout");

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("fault_cleared_by_rst", 32'(fault), 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
